data_mem_responder: RTL and testbench

Responder end of the core's data-memory port: accepts one load/store request at a time from the datapath/controller side (address, store data, write flag, access size). It performs the access against an internal word-organised RAM after a programmable number of wait states, and returns a single-cycle response with load data or an error flag. It sits between the RISC-V core's memory interface and the data RAM, and lets the bench exercise non-zero memory latency.

---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 155 +++++++++++++++
 tb/tb_data_mem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core's data-memory port and the responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, programmable wait states,
// word-organised RAM with byte lanes, single-cycle response pulse.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          WAIT_STATES = 2
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);

    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    // Latched request (data only, no reset needed)
    logic        write_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [1:0]  size_p0;
    logic        uns_p0;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] word_off;
    logic [AW-1:0] idx;
    logic        acc_err;
    logic [3:0]  be;
    logic [31:0] wlanes;
    logic [31:0] rword;
    logic [31:0] rdata_q;
    logic        err_q;

    // Byte-lane enables for a store of the given size at the given offset
    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   lane_enable = 4'b0001 << a;
            2'b01:   lane_enable = a[1] ? 4'b1100 : 4'b0011;
            default: lane_enable = 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data across every lane it may land in
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    // Select the addressed lane(s) and sign- or zero-extend
    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] size,
                                                input logic [1:0] a, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (size)
            2'b00:   load_extend = uns ? {24'd0, b} : 32'(b);
            2'b01:   load_extend = uns ? {16'd0, h} : 32'(h);
            default: load_extend = w;
        endcase
    endfunction

    assign word_off = (addr_p0 - ADDR_BASE) >> 2;
    assign idx      = word_off[AW-1:0];
    assign be       = lane_enable(size_p0, addr_p0[1:0]);
    assign wlanes   = lane_data(size_p0, wdata_p0);
    assign rword    = mem[idx];

    // Reject illegal size, misalignment and out-of-window addresses
    always_comb begin
        acc_err = 1'b0;
        if (size_p0 == 2'b11)                         acc_err = 1'b1;
        if (size_p0 == 2'b01 && addr_p0[0])           acc_err = 1'b1;
        if (size_p0 == 2'b10 && addr_p0[1:0] != 2'b0) acc_err = 1'b1;
        if (addr_p0 < ADDR_BASE)                      acc_err = 1'b1;
        if (word_off >= 32'(DEPTH_WORDS))             acc_err = 1'b1;
    end

    // State register and wait counter; reset returns to IDLE and drops any request
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: IDLE -> [WAIT] -> ACCESS -> RESP -> IDLE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    cnt_nxt   = WAIT_LOAD;
                    state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = ACCESS;
                else             cnt_nxt   = cnt - 4'd1;
            end
            ACCESS:  state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request on acceptance
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req_valid) begin
            write_p0 <= bus.req_write;
            addr_p0  <= bus.req_addr;
            wdata_p0 <= bus.req_wdata;
            size_p0  <= bus.req_size;
            uns_p0   <= bus.req_unsigned;
        end
    end

    // RAM write of the enabled lanes; an asserted reset suppresses the store
    always_ff @(posedge clk) begin
        if (reset && state == ACCESS && !acc_err && write_p0) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    // Response data/error registered at the ACCESS edge and held until the next one
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (state == ACCESS) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || write_p0) ? 32'd0
                                             : load_extend(rword, size_p0, addr_p0[1:0], uns_p0);
        end
    end

    assign bus.req_ready = (state == IDLE) && reset;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: main instance with two wait states,
// second instance with zero wait states and a non-zero base address.
module tb_data_mem_responder;
    localparam int W = 2;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if bus();
    data_mem_responder_if bus0();

    data_mem_responder #(.DEPTH_WORDS(256), .ADDR_BASE(32'h0000_0000), .WAIT_STATES(W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    data_mem_responder #(.DEPTH_WORDS(16), .ADDR_BASE(32'h0000_1000), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    bit   b2b = 1'b0;
    int   last_rsp = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Response monitor: pop the oldest expectation on every response pulse
    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("sb_empty", 32'(sbq.size()), 32'd1);
            end else begin
                e = sbq.pop_front();
                chk("rdata", bus.rsp_rdata, e.rdata);
                chk("err", {31'd0, bus.rsp_err}, {31'd0, e.err});
                chk("latency", cyc - e.cyc, 2 + W);
            end
            if (b2b && last_rsp >= 0) chk("spacing", cyc - last_rsp, 3 + W);
            last_rsp = cyc;
        end
    end

    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u,
                        input logic [31:0] exp_d, input logic exp_e, input bit hold);
        exp_t e;
        int   n;
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            chk("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
        end else begin
            e.rdata = exp_d;
            e.err   = exp_e;
            e.cyc   = cyc;
            sbq.push_back(e);
        end
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    task automatic send0(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic u,
                         input logic [31:0] exp_d, input logic exp_e);
        int n;
        int t0;
        bus0.req_valid    = 1'b1;
        bus0.req_write    = wr;
        bus0.req_addr     = a;
        bus0.req_wdata    = d;
        bus0.req_size     = sz;
        bus0.req_unsigned = u;
        n = 0;
        while (bus0.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        n = 0;
        while (bus0.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus0.rsp_valid !== 1'b1) begin
            chk("rsp0_timeout", {31'd0, bus0.rsp_valid}, 32'd1);
        end else begin
            chk("lat0", cyc - t0, 32'd2);
            chk("rdata0", bus0.rsp_rdata, exp_d);
            chk("err0", {31'd0, bus0.rsp_err}, {31'd0, exp_e});
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0;
        bus.req_valid = 1'b0;  bus.req_write = 1'b0;  bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0; bus.req_size = 2'b00;  bus.req_unsigned = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = 32'd0;
        bus0.req_wdata = 32'd0; bus0.req_size = 2'b00; bus0.req_unsigned = 1'b0;

        @(negedge clk);
        chk("rst_ready_low", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, bus.rsp_err}, 32'd0);

        send(1, 32'h10, 32'hDEAD_BEEF, 2'b10, 0, 32'h0, 0, 0);
        send(0, 32'h10, 32'h0,         2'b10, 0, 32'hDEAD_BEEF, 0, 0);
        send(1, 32'h12, 32'h0000_0055, 2'b00, 0, 32'h0, 0, 0);
        send(0, 32'h10, 32'h0,         2'b10, 0, 32'hDE55_BEEF, 0, 0);
        send(0, 32'h12, 32'h0,         2'b01, 0, 32'hFFFF_DE55, 0, 0);
        send(0, 32'h12, 32'h0,         2'b01, 1, 32'h0000_DE55, 0, 0);
        send(0, 32'h13, 32'h0,         2'b00, 1, 32'h0000_00DE, 0, 0);
        send(0, 32'h11, 32'h0,         2'b00, 0, 32'hFFFF_FFBE, 0, 0);
        send(0, 32'h12, 32'h0,         2'b00, 0, 32'h0000_0055, 0, 0);

        send(1, 32'h0,   32'h1122_3344, 2'b10, 0, 32'h0, 0, 0);
        send(1, 32'h3FC, 32'hA5A5_5A5A, 2'b10, 0, 32'h0, 0, 0);
        send(0, 32'h3FC, 32'h0,         2'b10, 0, 32'hA5A5_5A5A, 0, 0);

        send(0, 32'h11,  32'h0,         2'b01, 0, 32'h0, 1, 0);
        send(1, 32'h402, 32'hFFFF_FFFF, 2'b10, 0, 32'h0, 1, 0);
        send(1, 32'h400, 32'hFFFF_FFFF, 2'b10, 0, 32'h0, 1, 0);
        send(1, 32'h10,  32'h0,         2'b11, 0, 32'h0, 1, 0);
        send(0, 32'h10,  32'h0,         2'b10, 0, 32'hDE55_BEEF, 0, 0);
        send(0, 32'h0,   32'h0,         2'b10, 0, 32'h1122_3344, 0, 0);
        drain();

        b2b = 1'b1;
        last_rsp = -1;
        send(0, 32'h10, 32'h0, 2'b10, 0, 32'hDE55_BEEF, 0, 1);
        send(0, 32'h12, 32'h0, 2'b01, 1, 32'h0000_DE55, 0, 1);
        send(0, 32'h13, 32'h0, 2'b00, 0, 32'hFFFF_FFDE, 0, 0);
        drain();
        b2b = 1'b0;

        send(1, 32'h20, 32'hCAFE_F00D, 2'b10, 0, 32'h0, 0, 0);
        drain();
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h20;
        bus.req_wdata = 32'h1234_5678; bus.req_size = 2'b10;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rstacc_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rstacc_ready_low", {31'd0, bus.req_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rstacc_rsp_valid2", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rstacc_ready", {31'd0, bus.req_ready}, 32'd1);
        send(0, 32'h20, 32'h0, 2'b10, 0, 32'hCAFE_F00D, 0, 0);
        drain();

        send0(1, 32'h1004, 32'h1357_9BDF, 2'b10, 0, 32'h0, 0);
        send0(0, 32'h1004, 32'h0,         2'b10, 0, 32'h1357_9BDF, 0);
        send0(0, 32'h1007, 32'h0,         2'b00, 1, 32'h0000_0013, 0);
        send0(0, 32'h0FFC, 32'h0,         2'b10, 0, 32'h0, 1);
        send0(0, 32'h1040, 32'h0,         2'b10, 0, 32'h0, 1);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
